// File: rtl/multicycle_ctrl.sv
// Multi-cycle core sequencer: fetch/decode/exec/mem/writeback control with
// handshaked memories, a per-request wait timeout and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             taken,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             dmem_req,
  output logic             dmem_wr,
  output logic             rf_we,
  output logic             halt,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT - 1);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               err_q, err_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               retire;
  logic               imem_req_c, ir_we_c, pc_we_c, pc_sel_c;
  logic               dmem_req_c, dmem_wr_c, rf_we_c;

  logic [6:0] opcode;
  logic       is_branch, is_load, is_store, is_jump, is_system, is_legal;

  assign opcode    = instr[6:0];
  assign is_branch = (opcode == OpBranch);
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_jump   = (opcode == OpJal) || (opcode == OpJalr);
  assign is_system = (opcode == OpSystem);
  assign is_legal  = (opcode == OpReg) || (opcode == OpImm) || is_load || is_store ||
                     is_branch || is_jump || (opcode == OpLui) || (opcode == OpAuipc);

  // Upper instruction bits are consumed by the datapath decoder, not here.
  logic unused_instr;
  assign unused_instr = ^instr[31:12];

  // Next-state, strobe and timeout logic.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    retire     = 1'b0;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 1'b0;
    dmem_req_c = 1'b0;
    dmem_wr_c  = 1'b0;
    rf_we_c    = 1'b0;

    case (state_q)
      StFetch: begin
        imem_req_c = 1'b1;
        if (imem_rdy) begin
          ir_we_c = 1'b1;
          state_d = StDecode;
        end else if (wait_q == WaitMax) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        if (is_legal) begin
          state_d = StExec;
        end else if (is_system) begin
          state_d = StHalt;
        end else begin
          state_d = StHalt;
          err_d   = 1'b1;
        end
      end
      StExec: begin
        if (is_branch) begin
          pc_we_c  = 1'b1;
          pc_sel_c = taken;
          retire   = 1'b1;
          state_d  = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req_c = 1'b1;
        dmem_wr_c  = is_store;
        if (dmem_rdy) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitMax) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        rf_we_c  = (instr[11:7] != 5'd0);
        pc_we_c  = 1'b1;
        pc_sel_c = is_jump;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        // Unused encodings 5/6 are treated as corruption.
        state_d = StHalt;
        err_d   = 1'b1;
      end
    endcase

    // Every new request (entry to FETCH or MEM) starts with a fresh wait count.
    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  assign halt_d    = (state_d == StHalt);
  assign instret_d = instret_q + CNT_W'(retire);

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      err_q     <= 1'b0;
      halt_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      halt_q    <= halt_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are killed combinationally while reset is asserted.
  assign imem_req = rst_n & imem_req_c;
  assign ir_we    = rst_n & ir_we_c;
  assign pc_we    = rst_n & pc_we_c;
  assign pc_sel   = rst_n & pc_sel_c;
  assign dmem_req = rst_n & dmem_req_c;
  assign dmem_wr  = rst_n & dmem_wr_c;
  assign rf_we    = rst_n & rf_we_c;

  assign halt    = halt_q;
  assign err     = err_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with TIMEOUT=4.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        taken, imem_rdy, dmem_rdy;
  logic        imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_wr, rf_we, halt, err;
  logic [2:0]  state;
  logic [7:0]  instret;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] AddiX1 = 32'h0050_0093;
  localparam logic [31:0] AddiX0 = 32'h0050_0013;
  localparam logic [31:0] Beq    = 32'h0000_0063;
  localparam logic [31:0] LwX1   = 32'h0000_2083;
  localparam logic [31:0] SwRd0  = 32'h0010_2023;
  localparam logic [31:0] JalX1  = 32'h0080_00EF;
  localparam logic [31:0] Bad7f  = 32'h0000_007F;
  localparam logic [31:0] Ecall  = 32'h0000_0073;

  // Strobe vector: imem_req ir_we pc_we pc_sel dmem_req dmem_wr rf_we
  localparam logic [6:0] SNone   = 7'b0000000;
  localparam logic [6:0] SFetch  = 7'b1000000;
  localparam logic [6:0] SFetchR = 7'b1100000;
  localparam logic [6:0] SWb     = 7'b0010001;
  localparam logic [6:0] SWbRd0  = 7'b0010000;
  localparam logic [6:0] SWbJmp  = 7'b0011001;
  localparam logic [6:0] SBrT    = 7'b0011000;
  localparam logic [6:0] SBrN    = 7'b0010000;
  localparam logic [6:0] SLoad   = 7'b0000100;
  localparam logic [6:0] SStore  = 7'b0010110;

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .taken    (taken),
    .imem_rdy (imem_rdy),
    .dmem_rdy (dmem_rdy),
    .imem_req (imem_req),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .dmem_req (dmem_req),
    .dmem_wr  (dmem_wr),
    .rf_we    (rf_we),
    .halt     (halt),
    .err      (err),
    .state    (state),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  logic [6:0] strb;
  assign strb = {imem_req, ir_we, pc_we, pc_we & pc_sel, dmem_req, dmem_req & dmem_wr, rf_we};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Settle after input changes, then check state and strobes.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [6:0] estr);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".strb"}, 32'(strb), 32'(estr));
  endtask

  task automatic status(input string tag, input int ecnt, input logic eh, input logic ee);
    chk({tag, ".instret"}, 32'(instret), 32'(ecnt));
    chk({tag, ".halt"}, 32'(halt), 32'(eh));
    chk({tag, ".err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; taken = 1'b0; imem_rdy = 1'b1; dmem_rdy = 1'b0;
    #3;
    cyc("rst", 3'd0, SNone);
    status("rst", 0, 1'b0, 1'b0);

    // ADDI x1 with zero-wait fetch
    tick(); rst_n = 1'b1; instr = AddiX1;
    cyc("addi.f", 3'd0, SFetchR);
    tick(); cyc("addi.d", 3'd1, SNone);
    tick(); cyc("addi.e", 3'd2, SNone);
    tick(); cyc("addi.w", 3'd4, SWb);
    tick(); instr = Beq; taken = 1'b1;
    cyc("beq1.f", 3'd0, SFetchR);
    status("addi", 1, 1'b0, 1'b0);

    // BEQ taken then not taken
    tick(); cyc("beq1.d", 3'd1, SNone);
    tick(); cyc("beq1.e", 3'd2, SBrT);
    tick(); taken = 1'b0;
    cyc("beq2.f", 3'd0, SFetchR);
    tick(); cyc("beq2.d", 3'd1, SNone);
    tick(); cyc("beq2.e", 3'd2, SBrN);
    tick(); instr = LwX1;
    cyc("lw.f", 3'd0, SFetchR);
    status("beq", 3, 1'b0, 1'b0);

    // LW with 3 wait cycles; ready lands exactly at the timeout limit
    tick(); cyc("lw.d", 3'd1, SNone);
    tick(); cyc("lw.e", 3'd2, SNone);
    tick(); cyc("lw.m0", 3'd3, SLoad);
    tick(); cyc("lw.m1", 3'd3, SLoad);
    tick(); cyc("lw.m2", 3'd3, SLoad);
    tick(); dmem_rdy = 1'b1;
    cyc("lw.m3", 3'd3, SLoad);
    tick(); dmem_rdy = 1'b0;
    cyc("lw.w", 3'd4, SWb);
    tick(); instr = SwRd0;
    cyc("sw.f", 3'd0, SFetchR);
    status("lw", 4, 1'b0, 1'b0);

    // SW with rd field 0, no WB state
    tick(); cyc("sw.d", 3'd1, SNone);
    tick(); cyc("sw.e", 3'd2, SNone);
    tick(); dmem_rdy = 1'b1;
    cyc("sw.m", 3'd3, SStore);
    tick(); dmem_rdy = 1'b0; instr = JalX1;
    cyc("jal.f", 3'd0, SFetchR);
    status("sw", 5, 1'b0, 1'b0);

    // JAL selects target
    tick(); cyc("jal.d", 3'd1, SNone);
    tick(); cyc("jal.e", 3'd2, SNone);
    tick(); cyc("jal.w", 3'd4, SWbJmp);
    tick(); instr = AddiX0;
    cyc("x0.f", 3'd0, SFetchR);

    // ADDI to x0 never writes the register file
    tick(); cyc("x0.d", 3'd1, SNone);
    tick(); cyc("x0.e", 3'd2, SNone);
    tick(); cyc("x0.w", 3'd4, SWbRd0);
    tick(); instr = Bad7f;
    cyc("bad.f", 3'd0, SFetchR);
    status("x0", 7, 1'b0, 1'b0);

    // Illegal opcode
    tick(); cyc("bad.d", 3'd1, SNone);
    tick(); cyc("bad.h", 3'd7, SNone);
    status("bad", 7, 1'b1, 1'b1);
    tick(); cyc("bad.h2", 3'd7, SNone);

    // ECALL after reset halts without error
    rst_n = 1'b0; #1;
    status("rst2", 0, 1'b0, 1'b0);
    tick(); rst_n = 1'b1; instr = Ecall;
    cyc("ecall.f", 3'd0, SFetchR);
    tick(); cyc("ecall.d", 3'd1, SNone);
    tick(); cyc("ecall.h", 3'd7, SNone);
    status("ecall", 0, 1'b1, 1'b0);

    // Fetch timeout with TIMEOUT=4
    rst_n = 1'b0; imem_rdy = 1'b0;
    tick(); rst_n = 1'b1;
    cyc("to.0", 3'd0, SFetch);
    tick(); cyc("to.1", 3'd0, SFetch);
    tick(); cyc("to.2", 3'd0, SFetch);
    tick(); cyc("to.3", 3'd0, SFetch);
    tick(); cyc("to.h", 3'd7, SNone);
    status("to", 0, 1'b1, 1'b1);
    tick(); imem_rdy = 1'b1;
    cyc("to.late", 3'd7, SNone);
    tick(); cyc("to.late2", 3'd7, SNone);

    // Async reset in the middle of a load
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; instr = AddiX1;
    cyc("ar.addi.f", 3'd0, SFetchR);
    tick(); tick(); tick();
    cyc("ar.addi.w", 3'd4, SWb);
    tick(); instr = LwX1;
    cyc("ar.lw.f", 3'd0, SFetchR);
    status("ar.pre", 1, 1'b0, 1'b0);
    tick(); tick(); tick();
    cyc("ar.lw.m", 3'd3, SLoad);
    #2; rst_n = 1'b0; #1;
    chk("ar.dmem_req", 32'(dmem_req), 32'd0);
    chk("ar.state", 32'(state), 32'd0);
    chk("ar.instret", 32'(instret), 32'd0);
    tick(); rst_n = 1'b1; imem_rdy = 1'b0;
    cyc("ar.rel", 3'd0, SFetch);
    status("ar.rel", 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
